// File: rtl/clock_pkg.sv
// Shared constants and types for the alarm-clock time-keeping digits.
// Digit moduli, their register widths and the count-direction encoding.
package clock_pkg;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HR24_MOD = 24;
  localparam int HR12_MOD = 12;

  localparam int SEC_W = 6;
  localparam int HR_W  = 5;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/mod_n_updown_counter_next_value.sv
// Wrap arithmetic for a modulo-MODULUS digit; purely combinational, no backpressure.
// Terminal values are compared before stepping so no intermediate exceeds WIDTH bits.
module mod_next_value
  import clock_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int MODULUS = 24
) (
  input  logic [WIDTH-1:0] count,
  input  logic             updown,
  output logic [WIDTH-1:0] next_count
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  always_comb begin
    next_count = count;
    if (dir_e'(updown) == DIR_UP) begin
      next_count = (count == MAX_VAL) ? '0 : count + WIDTH'(1);
    end else begin
      next_count = (count == '0) ? MAX_VAL : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down digit with cascade carry/borrow; 1-cycle step/load latency, no backpressure.
// Optional synchronous parallel load ports are present only when MOD_COUNTER_LOAD_EN is defined.
module mod_n_updown_counter
  import clock_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int MODULUS     = 24,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             updown,
`ifdef MOD_COUNTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`endif
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] step_value;

  mod_next_value #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count      (count),
    .updown     (updown),
    .next_count (step_value)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RST_VAL;
`ifdef MOD_COUNTER_LOAD_EN
    end else if (load) begin
      // Out-of-range loads clamp to the top state so count stays legal.
      count <= (load_value > MAX_VAL) ? MAX_VAL : load_value;
`endif
    end else if (en) begin
      count <= step_value;
    end
  end

  assign at_max  = (count == MAX_VAL);
  assign at_zero = (count == '0);
  assign carry   = en & (dir_e'(updown) == DIR_UP) & at_max;
  assign borrow  = en & (dir_e'(updown) == DIR_DOWN) & at_zero;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Scoreboard bench: mod-24 and mod-60 digits plus a sec/min/hr cascade.
// Load checks are compiled only when MOD_COUNTER_LOAD_EN is defined.
module tb_mod_n_updown_counter;
  import clock_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // mod-24 digit
  logic       en0, ud0, ld0;
  logic [4:0] lv0, cnt0;
  logic       cy0, bw0, mx0, zr0;
  // mod-60 digit
  logic       en1, ud1;
  logic [5:0] cnt1;
  logic       cy1, bw1, mx1, zr1;
  // cascade
  logic       en_s, ud_c;
  logic [SEC_W-1:0] sec, mins;
  logic [HR_W-1:0]  hr;
  logic s_cy, s_bw, s_mx, s_zr, m_cy, m_bw, m_mx, m_zr, h_cy, h_bw, h_mx, h_zr;
  logic m_en, h_en;
  assign m_en = s_cy | s_bw;
  assign h_en = m_cy | m_bw;

  mod_n_updown_counter #(.WIDTH(5), .MODULUS(24), .RESET_VALUE(0)) u0 (
    .clk(clk), .reset(rst), .en(en0), .updown(ud0),
`ifdef MOD_COUNTER_LOAD_EN
    .load(ld0), .load_value(lv0),
`endif
    .count(cnt0), .carry(cy0), .borrow(bw0), .at_max(mx0), .at_zero(zr0));

  mod_n_updown_counter #(.WIDTH(6), .MODULUS(60), .RESET_VALUE(0)) u1 (
    .clk(clk), .reset(rst), .en(en1), .updown(ud1),
`ifdef MOD_COUNTER_LOAD_EN
    .load(1'b0), .load_value(6'd0),
`endif
    .count(cnt1), .carry(cy1), .borrow(bw1), .at_max(mx1), .at_zero(zr1));

  mod_n_updown_counter #(.WIDTH(SEC_W), .MODULUS(SEC_MOD), .RESET_VALUE(58)) u_sec (
    .clk(clk), .reset(rst), .en(en_s), .updown(ud_c),
`ifdef MOD_COUNTER_LOAD_EN
    .load(1'b0), .load_value(6'd0),
`endif
    .count(sec), .carry(s_cy), .borrow(s_bw), .at_max(s_mx), .at_zero(s_zr));

  mod_n_updown_counter #(.WIDTH(SEC_W), .MODULUS(MIN_MOD), .RESET_VALUE(59)) u_min (
    .clk(clk), .reset(rst), .en(m_en), .updown(ud_c),
`ifdef MOD_COUNTER_LOAD_EN
    .load(1'b0), .load_value(6'd0),
`endif
    .count(mins), .carry(m_cy), .borrow(m_bw), .at_max(m_mx), .at_zero(m_zr));

  mod_n_updown_counter #(.WIDTH(HR_W), .MODULUS(HR24_MOD), .RESET_VALUE(23)) u_hr (
    .clk(clk), .reset(rst), .en(h_en), .updown(ud_c),
`ifdef MOD_COUNTER_LOAD_EN
    .load(1'b0), .load_value(5'd0),
`endif
    .count(hr), .carry(h_cy), .borrow(h_bw), .at_max(h_mx), .at_zero(h_zr));

  typedef struct {
    string tag;
    int    sel;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int m0, m1, ms, mm, mh;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int nxt(input int c, input int up, input int modulus);
    if (up != 0) return (c == modulus - 1) ? 0 : c + 1;
    return (c == 0) ? modulus - 1 : c - 1;
  endfunction

  function automatic int obs(input int sel);
    case (sel)
      0: return int'(cnt0);
      1: return int'(cnt1);
      2: return int'(sec);
      3: return int'(mins);
      default: return int'(hr);
    endcase
  endfunction

  function automatic exp_t mk(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    return e;
  endfunction

  // Advance one edge, then compare every expectation queued for it.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic flags0(input string tag);
    chk({tag, "_cy0"}, int'(cy0), int'(en0 && ud0 && m0 == 23));
    chk({tag, "_bw0"}, int'(bw0), int'(en0 && !ud0 && m0 == 0));
    chk({tag, "_mx0"}, int'(mx0), int'(m0 == 23));
    chk({tag, "_zr0"}, int'(zr0), int'(m0 == 0));
  endtask

  task automatic reset_models();
    m0 = 0; m1 = 0; ms = 58; mm = 59; mh = 23;
  endtask

  initial begin
    int se, me;
    rst = 1'b1;
    en0 = 0; ud0 = 1; ld0 = 0; lv0 = '0;
    en1 = 0; ud1 = 0; en_s = 0; ud_c = 1;
    reset_models();
    #3;
    chk("rst_cnt0", int'(cnt0), 0);
    chk("rst_zr0", int'(zr0), 1);
    chk("rst_mx0", int'(mx0), 0);
    chk("rst_cy0", int'(cy0), 0);
    chk("rst_sec", int'(sec), 58);
    chk("rst_min", int'(mins), 59);
    chk("rst_hr", int'(hr), 23);
    #9 rst = 1'b0;

    // Cascade from 23:59:58 counting up.
    en_s = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      se = int'(ms == 59);
      me = int'(se != 0 && mm == 59);
      chk("casc_min_en", int'(m_en), se);
      chk("casc_hr_en", int'(h_en), me);
      ms = nxt(ms, 1, 60);
      if (se != 0) mm = nxt(mm, 1, 60);
      if (me != 0) mh = nxt(mh, 1, 24);
      exp_q.push_back(mk("casc_sec", 2, ms));
      exp_q.push_back(mk("casc_min", 3, mm));
      exp_q.push_back(mk("casc_hr", 4, mh));
      tick();
    end
    en_s = 0;

    // Up wrap on mod-24, down wrap on mod-60, together.
    en0 = 1; ud0 = 1; en1 = 1; ud1 = 0;
    for (int i = 0; i < 26; i++) begin
      #1;
      flags0("upw");
      chk("dnw_bw1", int'(bw1), int'(m1 == 0));
      chk("dnw_mx1", int'(mx1), int'(m1 == 59));
      m0 = nxt(m0, 1, 24);
      m1 = nxt(m1, 0, 60);
      exp_q.push_back(mk("upw_cnt0", 0, m0));
      exp_q.push_back(mk("dnw_cnt1", 1, m1));
      tick();
    end
    en1 = 0;

    // Step to 9, then assert reset between edges.
    for (int i = 0; i < 30 && m0 != 9; i++) begin
      m0 = nxt(m0, 1, 24);
      exp_q.push_back(mk("pre_rst_cnt0", 0, m0));
      tick();
    end
    chk("pre_rst_at9", int'(cnt0), 9);
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt0", int'(cnt0), 0);
    chk("arst_zr0", int'(zr0), 1);
    @(posedge clk);
    #1;
    chk("arst_hold_cnt0", int'(cnt0), 0);
    chk("arst_hold_sec", int'(sec), 58);
    en0 = 0;
    #1;
    chk("arst_cy0", int'(cy0), 0);
    chk("arst_bw0", int'(bw0), 0);
    #2 rst = 1'b0;
    reset_models();

`ifdef MOD_COUNTER_LOAD_EN
    ld0 = 1; lv0 = 5'd17; en0 = 0;
    exp_q.push_back(mk("load17", 0, 17));
    tick();
    m0 = 17;
    lv0 = 5'd30;
    exp_q.push_back(mk("load30_clamp", 0, 23));
    tick();
    m0 = 23;
    lv0 = 5'd5; en0 = 1; ud0 = 1;
    #1;
    chk("load_en_cy0", int'(cy0), 1);
    exp_q.push_back(mk("load_en_nostep", 0, 5));
    tick();
    m0 = 5;
    ld0 = 0; en0 = 0;
`endif

    // Random enable and direction every cycle.
    for (int i = 0; i < 40; i++) begin
      en0 = 1'($urandom_range(0, 1));
      ud0 = 1'($urandom_range(0, 1));
      #1;
      flags0("rnd");
      if (en0) m0 = nxt(m0, int'(ud0), 24);
      exp_q.push_back(mk("rnd_cnt0", 0, m0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mod_n_updown_counter.md
# mod_n_updown_counter

Parametrised modulo-N up/down counter with synchronous parallel load and cascade carry/borrow outputs. It is the common time-keeping digit for the alarm clock, covering seconds (N=60), minutes (N=60), hours (N=24 or 12) and alarm-set registers. Several instances chain through `carry`/`borrow` into a full clock in which every digit steps on the same clock edge.

## Interface
Parameters:
- `WIDTH`, default 5: count width in bits. Requires `2**WIDTH >= MODULUS`.
- `MODULUS`, default 24: number of states; count range is 0 to MODULUS-1. Requires MODULUS ≥ 2.
- `RESET_VALUE`, default 0: count after reset. Requires RESET_VALUE < MODULUS.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high. Forces `count` to RESET_VALUE immediately.
- `en` input 1: step enable; one step per enabled cycle.
- `updown` input 1: 1 = count up, 0 = count down.
- `load` input 1: synchronous parallel load (only with MOD_COUNTER_LOAD_EN).
- `load_value` input WIDTH: value to load (only with MOD_COUNTER_LOAD_EN).
- `count` output WIDTH: current value, registered.
- `carry` output 1: combinational; `en & updown & (count == MODULUS-1)`.
- `borrow` output 1: combinational; `en & ~updown & (count == 0)`.
- `at_max` output 1: combinational; `count == MODULUS-1`.
- `at_zero` output 1: combinational; `count == 0`.

## Operation
- Priority, highest first: `reset`, then `load`, then `en`, then hold.
- Up step: MODULUS-1 → 0, otherwise count+1.
- Down step: 0 → MODULUS-1, otherwise count-1.
- Load: `count <= load_value` when `load_value < MODULUS`. Otherwise `count <= MODULUS-1` (clamp; never enters an illegal state).
- `load` overrides `en` in the same cycle: no step occurs and `carry`/`borrow` are still generated from `en`/`count`.
  - Cascade users must deassert `en` while loading.
- `count` never leaves 0..MODULUS-1 under any input sequence.
- No arithmetic overflow: next-value logic compares against MODULUS-1 and 0 before adding or subtracting. Intermediate values are WIDTH bits.
- Cascading: drive the next digit's `en` from this digit's `carry | borrow` and share `updown`. Example: seconds 59 → 0 and minutes +1 happen on the same edge.

## Timing
- While `reset` is high: `count` = RESET_VALUE. `at_zero`/`at_max` follow from that value. `carry`/`borrow` = 0 only if `en` = 0.
- Reset deassertion is synchronised externally; the first step occurs on the first rising edge after release with `en` = 1.
- Step and load latency: 1 cycle; the new `count` is visible after the edge.
- `carry`/`borrow` latency: 0 cycles, valid in the same cycle as the terminal `count` with `en` high.
- Reset asserted mid-operation discards any pending load or step with no glitch on `count` beyond the asynchronous transition to RESET_VALUE.
- `updown` may change every cycle; each edge uses the value sampled at that edge.

## Configuration
- `MOD_COUNTER_LOAD_EN` defined: `load` and `load_value` ports exist, and load behaves as described in Operation.
- `MOD_COUNTER_LOAD_EN` undefined:
  - The ports are absent and the load logic is removed.
  - Priority reduces to reset, then `en`, then hold.
  - All other behaviour is identical.

## Structure
Shared package `clock_pkg` holds:
- Constants `SEC_MOD = 60`, `MIN_MOD = 60`, `HR24_MOD = 24`, `HR12_MOD = 12`.
- The derived widths `SEC_W = 6`, `HR_W = 5`.

One combinational sub-module, `mod_next_value` (inputs `count`, `updown`; output next value), holds the wrap arithmetic. The top level holds the register, the load clamp and the flags.

## Test plan
- Up wrap: MODULUS=24, hold `en=1`, `updown=1` from reset. Expect `count` 0..23, then 0. `carry`=1 only while `count`=23.
- Down wrap: MODULUS=60, from reset, `en=1`, `updown=0`. Expect `count` 0 → 59 → 58. `borrow`=1 only during the `count`=0 cycle.
- Load:
  - `load_value`=17 → `count`=17 next cycle.
  - `load_value`=30 with MODULUS=24 → `count`=23.
  - `load` and `en` together → loaded value, no step.
- Async reset: assert `reset` mid-count at `count`=9 between clock edges. `count` = RESET_VALUE before the next edge and holds while `reset` is high.
- Cascade: seconds (60) → minutes (60) → hours (24) chain, counting up from 23:59:58. After 2 edges expect 00:00:00, with all three digits wrapping on the same edge.
- Macro off: build without `MOD_COUNTER_LOAD_EN`. Up/down wrap tests pass unchanged and the load ports are absent.
